rv32i_datapath: RTL and testbench
=================================

Name: rv32i_datapath

Overview:
- Single-cycle RV32I datapath: PC register, next-PC logic, 32x32 register file, immediate extender, ALU and result-writeback mux.
- All control (branch, jump, resultSrc, inmSrc, regWrite, aluSrc, aluControl) comes from an external control unit. The datapath returns decoded opcode/funct fields, ALU result and zero flag.
- Instruction memory and data memory are external: the block outputs `pc`, `aluRes` (address) and `writeData`, and takes in `instr` and `readData`.

Parameters:
- PC_W, 16, width of the program counter / instruction address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- branch  in  1  conditional-branch instruction in flight
- jump  in  1  unconditional jump (JAL)
- readData  in  32  data-memory read value
- resultSrc  in  2  writeback select
- inmSrc  in  2  immediate format select
- instr  in  32  current instruction word
- regWrite  in  1  register-file write enable
- aluSrc  in  1  ALU operand B select (0 = rs2 value, 1 = immediate)
- aluControl  in  3  ALU operation
- aluRes  out  32  ALU result (also data-memory address)
- zero  out  1  high when aluRes == 0
- op  out  7  instr[6:0]
- f3  out  3  instr[14:12]
- f7  out  1  instr[30]
- writeData  out  32  register rs2 read value (store data)
- pc  out  PC_W  current program counter

Behaviour:
- Field extraction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- PC register:
  - rst_n low → pc = RESET_PC immediately (async).
  - Otherwise pc updates on every rising clk; no stall input.
- Next-PC:
  - pcSrc = (branch & zero) | jump.
  - pcNext = pcSrc ? pc + immExt[PC_W-1:0] : pc + 4.
  - Arithmetic is modulo 2^PC_W (wrap-around, no error).
- pcPlus4 = pc + 4, zero-extended to 32 bits for writeback.
- Register file:
  - 32 x 32 bits, two combinational read ports, one synchronous write port.
  - Writes on rising clk when regWrite=1 and rd≠0; x0 always reads 0.
  - Read-during-write returns the old value (the new value is visible next cycle).
  - Registers are not cleared by reset.
- Immediate extender (sign-extended to 32 bits):
  - 00 I: instr[31:20]
  - 01 S: {instr[31:25], instr[11:7]}
  - 10 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - 11 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- ALU: srcA = rs1 value, srcB = aluSrc ? immExt : rs2 value.
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed, result 0/1)
  - 110 srl (shift amount srcB[4:0])
  - 111 sll (shift amount srcB[4:0])
  - 32-bit results; overflow is ignored.
- zero = (aluRes == 32'b0), combinational.
- Writeback result:
  - 00 aluRes
  - 01 readData
  - 10 pcPlus4
  - 11 see Optional Feature
- writeData = rs2 read value, combinational.
- op/f3/f7 are pure combinational slices of instr.
- Simultaneous jump and branch: pcSrc=1 (jump dominates).
- Reset asserted mid-cycle forces pc to RESET_PC immediately; any pending register write on that edge is still governed by regWrite.

Optional Feature:
- Macro DATAPATH_LUI_EN.
  - Defined: resultSrc=11 writes the U-type value {instr[31:12], 12'b0} to rd (LUI support).
  - Undefined: resultSrc=11 behaves identically to 00 (aluRes).

Test Plan:
- Reset: rst_n=0 with clk running → pc=0 asynchronously; release rst_n, jump=0, branch=0 → pc=4, 8, 12 on successive edges.
- JAL: instr=32'h008000EF (jal x1,+8) at pc=0, jump=1, resultSrc=10, regWrite=1, inmSrc=11 → next pc=8; x1=4.
- ADDI/ADD: addi x2,x0,5 (aluSrc=1, aluControl=000) then add x3,x2,x2 (aluSrc=0) → aluRes=10, zero=0, x3=10; a write to x0 leaves x0 reading 0.
- BEQ: x2=x2 compare with aluControl=001, branch=1, inmSrc=10, imm=-4 at pc=16 → zero=1, pc=12. With unequal operands → pc=20.
- Store/load: sw with inmSrc=01, imm=8, rs1=0 → aluRes=8, writeData=rs2 value. lw with readData=32'hDEADBEEF, resultSrc=01 → rd=32'hDEADBEEF.
- Field decode / wrap: instr=32'h40A485B3 → op=7'h33, f3=0, f7=1. pc=16'hFFFC with no jump → next pc=0.

Source files
------------

// File: rtl/rv32i_datapath_if.sv
// rtl/rv32i_datapath_if.sv - control, memory and decode signals between the RV32I datapath and its surroundings
interface rv32i_datapath_if #(
    parameter int PC_W = 16
);
    logic            branch;
    logic            jump;
    logic [31:0]     readData;
    logic [1:0]      resultSrc;
    logic [1:0]      inmSrc;
    logic [31:0]     instr;
    logic            regWrite;
    logic            aluSrc;
    logic [2:0]      aluControl;
    logic [31:0]     aluRes;
    logic            zero;
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            f7;
    logic [31:0]     writeData;
    logic [PC_W-1:0] pc;

    modport master (
        output branch, jump, readData, resultSrc, inmSrc, instr,
               regWrite, aluSrc, aluControl,
        input  aluRes, zero, op, f3, f7, writeData, pc
    );

    modport slave (
        input  branch, jump, readData, resultSrc, inmSrc, instr,
               regWrite, aluSrc, aluControl,
        output aluRes, zero, op, f3, f7, writeData, pc
    );
endinterface

// File: rtl/rv32i_datapath.sv
// rtl/rv32i_datapath.sv - single-cycle RV32I datapath (PC, regfile, immediates, ALU, writeback)
// Optional LUI writeback on resultSrc=11 when DATAPATH_LUI_EN is defined.
module rv32i_datapath #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst_n,
    rv32i_datapath_if.slave bus
);
    logic [4:0]      rs1, rs2, rd;
    logic [31:0]     rf [0:31];
    logic [31:0]     rd1, rd2;
    logic [31:0]     imm_ext;
    logic [31:0]     src_b;
    logic [31:0]     alu_res;
    logic [31:0]     result;
    logic [31:0]     pc_plus4_ext;
    logic [PC_W-1:0] pc_q, pc_plus4, pc_target, pc_next;
    logic            pc_src;

    assign rs1 = bus.instr[19:15];
    assign rs2 = bus.instr[24:20];
    assign rd  = bus.instr[11:7];

    assign bus.op = bus.instr[6:0];
    assign bus.f3 = bus.instr[14:12];
    assign bus.f7 = bus.instr[30];

    always_comb begin
        imm_ext = {{20{bus.instr[31]}}, bus.instr[31:20]};
        case (bus.inmSrc)
            2'b00: imm_ext = {{20{bus.instr[31]}}, bus.instr[31:20]};
            2'b01: imm_ext = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            2'b10: imm_ext = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                              bus.instr[30:25], bus.instr[11:8], 1'b0};
            2'b11: imm_ext = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                              bus.instr[20], bus.instr[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // x0 is hardwired; rf[0] is never written and never observed
    assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    always_ff @(posedge clk) begin
        if (bus.regWrite && (rd != 5'd0)) begin
            rf[rd] <= result;
        end
    end

    assign src_b = bus.aluSrc ? imm_ext : rd2;

    always_comb begin
        alu_res = '0;
        case (bus.aluControl)
            3'b000: alu_res = rd1 + src_b;
            3'b001: alu_res = rd1 - src_b;
            3'b010: alu_res = rd1 & src_b;
            3'b011: alu_res = rd1 | src_b;
            3'b100: alu_res = rd1 ^ src_b;
            3'b101: alu_res = {31'd0, $signed(rd1) < $signed(src_b)};
            3'b110: alu_res = rd1 >> src_b[4:0];
            3'b111: alu_res = rd1 << src_b[4:0];
            default: alu_res = '0;
        endcase
    end

    assign bus.aluRes    = alu_res;
    assign bus.zero      = (alu_res == 32'd0);
    assign bus.writeData = rd2;

    assign pc_plus4     = pc_q + PC_W'(4);
    assign pc_target    = pc_q + imm_ext[PC_W-1:0];
    assign pc_plus4_ext = 32'(pc_plus4);
    assign pc_src       = (bus.branch & bus.zero) | bus.jump;
    assign pc_next      = pc_src ? pc_target : pc_plus4;

    always_comb begin
        result = alu_res;
        case (bus.resultSrc)
            2'b00: result = alu_res;
            2'b01: result = bus.readData;
            2'b10: result = pc_plus4_ext;
`ifdef DATAPATH_LUI_EN
            2'b11: result = {bus.instr[31:12], 12'd0};
`else
            2'b11: result = alu_res;
`endif
            default: result = alu_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign bus.pc = pc_q;
endmodule

// File: tb/tb_rv32i_datapath.sv
// tb/tb_rv32i_datapath.sv - scoreboard bench for the single-cycle RV32I datapath
module tb_rv32i_datapath;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] got, exp;
    logic [31:0] exp_q[$];

    rv32i_datapath_if #(.PC_W(16)) bus ();

    rv32i_datapath #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl);
        case (ctl)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a >> b[4:0];
            default: return a << b[4:0];
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        bus.branch = 0; bus.jump = 0; bus.readData = '0; bus.resultSrc = 2'b00;
        bus.inmSrc = 2'b00; bus.instr = '0; bus.regWrite = 0; bus.aluSrc = 0;
        bus.aluControl = 3'b000;
    endtask

    task automatic test_reset();
        idle_ctrl();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", got, exp); end
        @(negedge clk);
        rst_n = 1;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(32'(4 * i));
            step();
            got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL pc_incr_%0d: got %h expected %h", i, got, exp); end
        end
        #2;
        rst_n = 0;
        exp_q.push_back(32'h0);
        #1;
        got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL async_reset: got %h expected %h", got, exp); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_jal();
        bus.instr = 32'h008000EF; bus.jump = 1; bus.resultSrc = 2'b10;
        bus.regWrite = 1; bus.inmSrc = 2'b11;
        exp_q.push_back(32'h8);
        step();
        got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL jal_pc: got %h expected %h", got, exp); end
        idle_ctrl();
        bus.instr = enc_r(5'd0, 5'd0, 5'd1);
        exp_q.push_back(32'h4);
        #1;
        got = bus.writeData; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL jal_link_x1: got %h expected %h", got, exp); end
    endtask

    task automatic test_addi_add();
        idle_ctrl();
        bus.instr = enc_i(5'd2, 5'd0, 12'd5); bus.aluSrc = 1; bus.regWrite = 1;
        exp_q.push_back(32'd5);
        #1;
        got = bus.aluRes; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL addi_alu: got %h expected %h", got, exp); end
        step();
        bus.instr = enc_r(5'd3, 5'd2, 5'd2); bus.aluSrc = 0;
        exp_q.push_back(32'd10); exp_q.push_back(32'd0); exp_q.push_back(32'd5);
        #1;
        got = bus.aluRes; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL add_alu: got %h expected %h", got, exp); end
        got = 32'(bus.zero); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL add_zero: got %h expected %h", got, exp); end
        got = bus.writeData; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL add_rs2: got %h expected %h", got, exp); end
        step();
        bus.instr = enc_i(5'd0, 5'd0, 12'd7); bus.aluSrc = 1;
        step();
        idle_ctrl();
        bus.instr = enc_r(5'd0, 5'd0, 5'd3);
        exp_q.push_back(32'd10);
        #1;
        got = bus.writeData; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL x3_value: got %h expected %h", got, exp); end
        bus.instr = enc_r(5'd0, 5'd0, 5'd0);
        exp_q.push_back(32'd0);
        #1;
        got = bus.writeData; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL x0_hardwired: got %h expected %h", got, exp); end
    endtask

    task automatic test_store_load();
        idle_ctrl();
        bus.instr = enc_s(5'd0, 5'd3, 12'd8); bus.inmSrc = 2'b01; bus.aluSrc = 1;
        exp_q.push_back(32'd8); exp_q.push_back(32'd10);
        #1;
        got = bus.aluRes; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL sw_addr: got %h expected %h", got, exp); end
        got = bus.writeData; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL sw_data: got %h expected %h", got, exp); end
        bus.instr = enc_i(5'd4, 5'd0, 12'd0); bus.inmSrc = 2'b00;
        bus.readData = 32'hDEADBEEF; bus.resultSrc = 2'b01; bus.regWrite = 1;
        step();
        idle_ctrl();
        bus.instr = enc_r(5'd0, 5'd0, 5'd4);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        got = bus.writeData; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lw_x4: got %h expected %h", got, exp); end
    endtask

    task automatic test_alu_ops();
        logic [11:0] imm;
        logic [31:0] r;
        idle_ctrl();
        for (int k = 0; k < 8; k++) begin
            imm = 12'($urandom);
            bus.instr = enc_i(5'd0, 5'd4, imm); bus.aluSrc = 1; bus.aluControl = 3'(k);
            r = alu_model(32'hDEADBEEF, {{20{imm[11]}}, imm}, 3'(k));
            exp_q.push_back(r); exp_q.push_back({31'd0, r == 32'd0});
            #1;
            got = bus.aluRes; exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL alu_imm_op%0d: got %h expected %h", k, got, exp); end
            got = 32'(bus.zero); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL alu_imm_zero%0d: got %h expected %h", k, got, exp); end
        end
        for (int k = 0; k < 8; k++) begin
            bus.instr = enc_r(5'd0, 5'd4, 5'd3); bus.aluSrc = 0; bus.aluControl = 3'(k);
            exp_q.push_back(alu_model(32'hDEADBEEF, 32'd10, 3'(k)));
            #1;
            got = bus.aluRes; exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL alu_reg_op%0d: got %h expected %h", k, got, exp); end
        end
    endtask

    task automatic test_beq();
        idle_ctrl();
        @(posedge clk); #1;
        rst_n = 0; #1; rst_n = 1;
        repeat (4) step();
        exp_q.push_back(32'd16);
        got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL beq_start_pc: got %h expected %h", got, exp); end
        bus.instr = enc_b(5'd2, 5'd2, 13'h1FFC); bus.branch = 1; bus.inmSrc = 2'b10; bus.aluControl = 3'b001;
        exp_q.push_back(32'd1); exp_q.push_back(32'd12);
        #1;
        got = 32'(bus.zero); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL beq_zero_taken: got %h expected %h", got, exp); end
        step();
        got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL beq_taken_pc: got %h expected %h", got, exp); end
        bus.branch = 0; bus.instr = '0;
        step();
        bus.instr = enc_b(5'd2, 5'd3, 13'h1FFC); bus.branch = 1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd20);
        #1;
        got = 32'(bus.zero); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL beq_zero_not_taken: got %h expected %h", got, exp); end
        step();
        got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL beq_not_taken_pc: got %h expected %h", got, exp); end
    endtask

    task automatic test_result_src3();
        logic [31:0] ins;
        idle_ctrl();
        ins = enc_i(5'd5, 5'd0, 12'h923);
        bus.instr = ins; bus.aluSrc = 1; bus.resultSrc = 2'b11; bus.regWrite = 1;
`ifdef DATAPATH_LUI_EN
        exp_q.push_back(ins & 32'hFFFFF000);
`else
        exp_q.push_back(32'hFFFFF923);
`endif
        step();
        idle_ctrl();
        bus.instr = enc_r(5'd0, 5'd0, 5'd5);
        #1;
        got = bus.writeData; exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL result_src3_x5: got %h expected %h", got, exp); end
    endtask

    task automatic test_decode_wrap();
        idle_ctrl();
        bus.instr = 32'h40A485B3;
        exp_q.push_back(32'h33); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        #1;
        got = 32'(bus.op); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL decode_op: got %h expected %h", got, exp); end
        got = 32'(bus.f3); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL decode_f3: got %h expected %h", got, exp); end
        got = 32'(bus.f7); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL decode_f7: got %h expected %h", got, exp); end
        idle_ctrl();
        rst_n = 0; #1; rst_n = 1;
        bus.instr = enc_j(5'd0, 21'h1FFFFC); bus.jump = 1; bus.inmSrc = 2'b11;
        exp_q.push_back(32'hFFFC); exp_q.push_back(32'h0000); exp_q.push_back(32'd20);
        step();
        got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL jump_neg_pc: got %h expected %h", got, exp); end
        bus.jump = 0; bus.instr = '0;
        step();
        got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL pc_wrap: got %h expected %h", got, exp); end
        bus.instr = enc_j(5'd0, 21'd20); bus.jump = 1; bus.branch = 1;
        step();
        got = 32'(bus.pc); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL jump_and_branch_pc: got %h expected %h", got, exp); end
        idle_ctrl();
    endtask

    initial begin
        test_reset();
        test_jal();
        test_addi_add();
        test_store_load();
        test_alu_ops();
        test_beq();
        test_result_src3();
        test_decode_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog timeout");
    end
endmodule
